cache_axi_bridge: RTL

Converts the single-outstanding SRAM-like bus driven by the data cache into single-beat AXI4 read and write transactions. It sits directly downstream of the data cache's memory-side port (`data_req`/`data_wr`/`data_addr_ok`/`data_data_ok`) and upstream of the AXI interconnect. It handles one transaction at a time, latches the request, and returns read data and completion as a one-cycle `data_data_ok` pulse.

---
 rtl/cache_axi_bridge_pkg.sv | 20 ++
 rtl/cache_axi_bridge.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// Shared types and AXI constants for the cache-to-AXI bridge.
package cache_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cache_axi_bridge.sv
// Single-outstanding SRAM-like cache port to single-beat AXI4 reads/writes.
// Accept-to-done is 3 cycles minimum; the cache is held off by data_addr_ok until IDLE.
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter int                   ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0]  AXI_ID   = '0
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [3:0]          data_wen,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic [31:0]         data_rdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,

    output logic [ID_WIDTH-1:0] arid,
    output logic                arvalid,
    input  logic                arready,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,

    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [ID_WIDTH-1:0] awid,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,

    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [ID_WIDTH-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,

    output logic                bus_err
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [3:0]  r_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_bus_err;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_unused;

    assign w_unused = ^{rid, bid, rlast};

    assign data_addr_ok = (r_state == ST_IDLE) && data_req;
    assign data_data_ok = (r_state == ST_DONE);
    assign data_rdata   = r_rdata;
    assign bus_err      = r_bus_err;

    assign arid    = AXI_ID;
    assign arvalid = (r_state == ST_RD_ADDR);
    assign araddr  = r_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, r_size};
    assign arburst = arvalid ? AXI_BURST_INCR : 2'b00;
    assign rready  = (r_state == ST_RD_DATA);

    // AW and W complete independently; each valid drops once its own handshake is done.
    assign awid    = AXI_ID;
    assign awvalid = (r_state == ST_WR_REQ) && !r_aw_done;
    assign awaddr  = r_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, r_size};
    assign awburst = (r_state == ST_WR_REQ) ? AXI_BURST_INCR : 2'b00;
    assign wvalid  = (r_state == ST_WR_REQ) && !r_w_done;
    assign wdata   = r_wdata;
    assign wstrb   = r_wen;
    assign wlast   = (r_state == ST_WR_REQ);
    assign bready  = (r_state == ST_WR_RESP);

    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (data_req) w_next = data_wr ? ST_WR_REQ : ST_RD_ADDR;
            ST_RD_ADDR: if (arready)  w_next = ST_RD_DATA;
            ST_RD_DATA: if (rvalid)   w_next = ST_DONE;
            ST_WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = ST_WR_RESP;
            ST_WR_RESP: if (bvalid)   w_next = ST_DONE;
            ST_DONE:                  w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_size    <= '0;
            r_wen     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (data_req) begin
                        r_addr    <= data_addr;
                        r_size    <= data_size;
                        r_wen     <= data_wen;
                        r_wdata   <= data_wdata;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        r_rdata <= rdata;
                        if (rresp != AXI_RESP_OKAY) r_bus_err <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                ST_WR_RESP: begin
                    if (bvalid && (bresp != AXI_RESP_OKAY)) r_bus_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
